// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with valid bit, stall/flush control, integrated
// load-use hazard detection and pre-split EX control outputs.
// Optional performance counters are built only when ID_EX_PERF_CNT_EN is
// defined; otherwise bubble_cnt_o and flush_cnt_o are constant 0.
module id_ex_stage_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    input  logic [1:0]            wb_i,
    input  logic [1:0]            m_i,
    input  logic [3:0]            ex_i,
    input  logic [DATA_W-1:0]     pc_i,
    input  logic [DATA_W-1:0]     rs_data_i,
    input  logic [DATA_W-1:0]     rt_data_i,
    input  logic [DATA_W-1:0]     imm_i,
    input  logic [REG_ADDR_W-1:0] rs_addr_i,
    input  logic [REG_ADDR_W-1:0] rt_addr_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    output logic                  valid_o,
    output logic [1:0]            wb_o,
    output logic [1:0]            m_o,
    output logic                  regdst_o,
    output logic [1:0]            aluop_o,
    output logic                  alusrc_o,
    output logic [DATA_W-1:0]     pc_o,
    output logic [DATA_W-1:0]     rs_data_o,
    output logic [DATA_W-1:0]     rt_data_o,
    output logic [DATA_W-1:0]     imm_o,
    output logic [REG_ADDR_W-1:0] rs_addr_o,
    output logic [REG_ADDR_W-1:0] rt_addr_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic                  hz_stall_o,
    output logic [CNT_W-1:0]      bubble_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    logic       hazard;
    logic [3:0] ex_reg;

    // Load-use hazard: a valid load in this stage whose destination (rt) is
    // read by the valid instruction now in decode; register 0 never hazards.
    always_comb begin
        hazard = 1'b0;
        if (valid_o && m_o[1] && valid_i && (rt_addr_o != '0) &&
            ((rt_addr_o == rs_addr_i) || (rt_addr_o == rt_addr_i))) begin
            hazard = 1'b1;
        end
    end

    assign hz_stall_o = hazard;

    // Pipeline register: flush beats stall, stall beats hazard bubble,
    // otherwise capture decode outputs with control zeroed for non-valid slots.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_o   <= 1'b0;
            wb_o      <= '0;
            m_o       <= '0;
            ex_reg    <= '0;
            pc_o      <= '0;
            rs_data_o <= '0;
            rt_data_o <= '0;
            imm_o     <= '0;
            rs_addr_o <= '0;
            rt_addr_o <= '0;
            rd_addr_o <= '0;
        end else if (flush_i || (!stall_i && hazard)) begin
            valid_o   <= 1'b0;
            wb_o      <= '0;
            m_o       <= '0;
            ex_reg    <= '0;
            pc_o      <= '0;
            rs_data_o <= '0;
            rt_data_o <= '0;
            imm_o     <= '0;
            rs_addr_o <= '0;
            rt_addr_o <= '0;
            rd_addr_o <= '0;
        end else if (!stall_i) begin
            valid_o   <= valid_i;
            wb_o      <= valid_i ? wb_i : 2'b00;
            m_o       <= valid_i ? m_i  : 2'b00;
            ex_reg    <= valid_i ? ex_i : 4'b0000;
            pc_o      <= pc_i;
            rs_data_o <= rs_data_i;
            rt_data_o <= rt_data_i;
            imm_o     <= imm_i;
            rs_addr_o <= rs_addr_i;
            rt_addr_o <= rt_addr_i;
            rd_addr_o <= rd_addr_i;
        end
    end

    assign regdst_o = ex_reg[3];
    assign aluop_o  = ex_reg[2:1];
    assign alusrc_o = ex_reg[0];

`ifdef ID_EX_PERF_CNT_EN
    logic [CNT_W-1:0] bubble_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Saturating event counters: flushes win over hazard bubbles, and a held
    // stage (stall without flush) counts nothing.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else if (flush_i) begin
            if (flush_cnt != '1) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end else if (!stall_i && hazard) begin
            if (bubble_cnt != '1) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end
    end

    assign bubble_cnt_o = bubble_cnt;
    assign flush_cnt_o  = flush_cnt;
`else
    assign bubble_cnt_o = '0;
    assign flush_cnt_o  = '0;
`endif

endmodule
